ram_block_copier: RTL
=====================

Name: ram_block_copier

Overview:
- Initiator/master for the 16x8 register RAM's ADDRESS / DATA_IN / OPCODE / DATA_OUT interface.
- On a START pulse it copies LEN bytes from SRC to DST inside that RAM, one byte at a time. Addresses wrap modulo 2^ADDR_W.
- It accumulates an 8-bit checksum of the bytes it copies and reports completion with BUSY and DONE.
- It sits between the control sequencer and the RAM, and owns the RAM port while BUSY is high.

Parameters:
- ADDR_W, 4, RAM address width; RAM depth is 2^ADDR_W.
- DATA_W, 8, RAM word width and checksum width.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  copy request, sampled on a rising edge while IDLE.
- SRC  in  ADDR_W  source start address, captured with START.
- DST  in  ADDR_W  destination start address, captured with START.
- LEN  in  ADDR_W+1  byte count, captured with START.
- BUSY  out  1  high while a copy is in progress.
- DONE  out  1  one-cycle pulse when a copy finishes.
- CHECKSUM  out  DATA_W  sum of the copied bytes, mod 2^DATA_W.
- RAM_ADDRESS  out  ADDR_W  drives the RAM ADDRESS.
- RAM_DATA_IN  out  DATA_W  drives the RAM DATA_IN.
- RAM_OPCODE  out  1  drives the RAM OPCODE: 0 = read, 1 = write.
- RAM_DATA_OUT  in  DATA_W  RAM read data; combinational from the RAM.

Behaviour:
- Reset values (asynchronous, all outputs): BUSY=0, DONE=0, CHECKSUM=0, RAM_ADDRESS=0, RAM_DATA_IN=0, RAM_OPCODE=0, state=IDLE.
- RAM_OPCODE deasserts immediately on RST, including mid-write.
- All RAM-side outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, READ, SETUP, WRITE, HOLD, FINISH.
- IDLE:
  - START=1 and LEN!=0: latch src/dst pointers, count = min(LEN, 2^ADDR_W); clear CHECKSUM; BUSY=1; go to READ.
  - START=1 and LEN=0: go to FINISH; no RAM access; CHECKSUM cleared.
- READ: RAM_ADDRESS=src, RAM_OPCODE=0. At the end of the cycle, capture RAM_DATA_OUT into the data register and add it to CHECKSUM.
- SETUP: RAM_ADDRESS=dst, RAM_DATA_IN=data, RAM_OPCODE=0. Gives address and data one full cycle to settle before write.
- WRITE: RAM_OPCODE=1. Address and data are unchanged from SETUP.
- HOLD: RAM_OPCODE=0. Address and data are still unchanged.
  - Then src and dst increment with wrap (0xF to 0x0) and count decrements.
  - count reaches 0: go to FINISH; otherwise go to READ.
- FINISH: DONE=1 for exactly one cycle, BUSY=0; go to IDLE.
- RAM-side invariant: RAM_ADDRESS and RAM_DATA_IN never change in a cycle where RAM_OPCODE=1, or in the cycle adjacent to it. This is required because the RAM write is level-sensitive.
- Timing: 4 cycles per byte. With START sampled at edge 0:
  - BUSY is high after edge 0.
  - The DONE pulse occurs in cycle 4*LEN+1.
  - DONE and BUSY are never high together.
- Overlap: the copy is strictly forward, byte by byte. If DST lies in (SRC, SRC+LEN), bytes already written are re-read; this is the defined behaviour and is not corrected.
- SRC = DST: each byte is rewritten with its own value.
- LEN > 2^ADDR_W is clamped to 2^ADDR_W.
- START while BUSY or FINISH is ignored. SRC, DST and LEN changes after capture have no effect.
- CHECKSUM holds its value after DONE until the next accepted START.
- RST mid-copy: returns to IDLE. Bytes already written stay written; no DONE pulse is generated.

Test Plan:
- Preload RAM[0..3]={11,22,33,44}; START SRC=0 DST=8 LEN=4 -> RAM[8..11]={11,22,33,44}; DONE pulse in cycle 17; CHECKSUM=0xAA; BUSY high for cycles 1..16.
- Wrap: RAM[14]=0x01, RAM[15]=0x02, RAM[0]=0x03; SRC=14 DST=4 LEN=3 -> RAM[4..6]={01,02,03}; CHECKSUM=0x06.
- LEN=0 -> DONE pulse in cycle 1, RAM_OPCODE never 1, CHECKSUM=0.
- LEN=20, RAM all 0xFF -> 16 bytes copied; DONE in cycle 65; CHECKSUM=0xF0.
- Overlap SRC=0 DST=1 LEN=3, RAM[0..3]={A0,A1,A2,A3} -> RAM[1..3]={A0,A0,A0}. Monitor asserts RAM_ADDRESS and RAM_DATA_IN are stable across every OPCODE=1 window.
- Assert RST during the WRITE of byte 2 of 4 -> RAM_OPCODE=0 immediately, BUSY=0, no DONE; a new START then completes normally. Also: a START pulse while BUSY is ignored.

Source files
------------

// File: rtl/ram_block_copier.sv
// ram_block_copier: moves LEN bytes from SRC to DST inside a small
// register RAM, one byte every four cycles. It reads, then presents the
// address and data for a full cycle, then writes, then holds. A running
// 8-bit checksum of the copied bytes is kept. Every RAM-side output comes
// straight from a flop, so the level-sensitive RAM write never sees a
// glitching address or data bus.
module ram_block_copier #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] checksum_o,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_data_in_o,
  output logic              ram_opcode_o,
  input  logic [DATA_W-1:0] ram_data_out_i
);

  // Full RAM depth, the largest byte count a single copy can move.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SETUP,
    WRITE,
    HOLD,
    FINISH
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   count_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] checksum_q;
  logic [ADDR_W-1:0] ram_address_q;
  // Holds the byte read in READ. It drives the RAM data bus directly, so no
  // separate copy of the byte is needed.
  logic [DATA_W-1:0] ram_data_in_q;
  logic              ram_opcode_q;

  logic [ADDR_W:0]   len_clamp_d;
  logic [ADDR_W-1:0] src_inc_d;
  logic [ADDR_W-1:0] dst_inc_d;
  logic [ADDR_W:0]   count_dec_d;

  // Clamp the requested length. Pointer increments wrap naturally at the
  // RAM depth.
  always_comb begin
    len_clamp_d = (len_i > DEPTH) ? DEPTH : len_i;
    src_inc_d   = src_q + 1'b1;
    dst_inc_d   = dst_q + 1'b1;
    count_dec_d = count_q - 1'b1;
  end

  // Copy sequencer. Each output register is loaded with the value that
  // belongs to the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      checksum_q    <= '0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_opcode_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            checksum_q <= '0;
            if (len_i != '0) begin
              src_q         <= src_i;
              dst_q         <= dst_i;
              count_q       <= len_clamp_d;
              busy_q        <= 1'b1;
              ram_address_q <= src_i;
              ram_opcode_q  <= 1'b0;
              state_q       <= READ;
            end else begin
              // Nothing to move: report completion without touching the RAM.
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        READ: begin
          checksum_q    <= checksum_q + ram_data_out_i;
          ram_data_in_q <= ram_data_out_i;
          ram_address_q <= dst_q;
          state_q       <= SETUP;
        end
        SETUP: begin
          ram_opcode_q <= 1'b1;
          state_q      <= WRITE;
        end
        WRITE: begin
          ram_opcode_q <= 1'b0;
          state_q      <= HOLD;
        end
        HOLD: begin
          src_q   <= src_inc_d;
          dst_q   <= dst_inc_d;
          count_q <= count_dec_d;
          if (count_dec_d == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            ram_address_q <= src_inc_d;
            state_q       <= READ;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign checksum_o    = checksum_q;
  assign ram_address_o = ram_address_q;
  assign ram_data_in_o = ram_data_in_q;
  assign ram_opcode_o  = ram_opcode_q;

endmodule
